// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) over WIDTH
// iterations. MTHI/MTLO write HI/LO directly in one cycle.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO handled here
// CALC  | one multiply/divide iteration per clock, WIDTH clocks
// FIX   | sign correction, HI/LO write, done pulse
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_opb;      // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic                 r_is_div;
  logic                 r_neg_res;  // product / quotient must be negated
  logic                 r_neg_rem;  // remainder must be negated
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_div_zero;

  logic                 w_md_op;
  logic                 w_signed;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // op[2]==0 selects multiply/divide; op[1] divide; op[0]==0 signed
  assign w_md_op  = ~op[2];
  assign w_signed = ~op[0];
  assign w_b_zero = (SrcB == '0);
  assign w_abs_a  = (w_signed && SrcA[WIDTH-1]) ? (~SrcA + 1'b1) : SrcA;
  assign w_abs_b  = (w_signed && SrcB[WIDTH-1]) ? (~SrcB + 1'b1) : SrcB;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: the remainder stays below the divisor, so the shifted
  // value fits in WIDTH+1 bits and bit WIDTH of the difference is the borrow.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_step  = w_div_diff[WIDTH] ?
                       {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                       {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a zero divisor bypasses CALC straight to FIX
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_md_op) w_next = (op[1] && w_b_zero) ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_md_op) begin
              r_cnt      <= '0;
              r_is_div   <= op[1];
              r_div_zero <= op[1] & w_b_zero;
              r_opb      <= op[1] ? w_abs_b : w_abs_a;
              r_acc      <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
              r_neg_res  <= w_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
              r_neg_rem  <= w_signed & SrcA[WIDTH-1];
            end else if (op == 3'b100) begin
              r_hi <= SrcA;
            end else if (op == 3'b101) begin
              r_lo <= SrcA;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= r_is_div ? w_div_step : w_mul_step;
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_div_zero) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter at WIDTH=32.
// Stimulus pushes expected HI/LO/div_zero and done cycle; a monitor pops on done.
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] SrcA, SrcB;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .SrcA(SrcA), .SrcB(SrcB), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           dcyc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_hi"},   hi,       mon_e.hi);
        chk({mon_e.name, "_lo"},   lo,       mon_e.lo);
        chk({mon_e.name, "_dz"},   div_zero, mon_e.dz);
        chk({mon_e.name, "_busy"}, busy,     1'b0);
        chk({mon_e.name, "_lat"},  cyc,      mon_e.dcyc);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy=%b expected 0 within 200 cycles", busy);
    end
  endtask

  // Issue one request; if b2b, drive start in the cycle where done is high
  task automatic issue(input string name, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic edz, input int lat, input bit b2b);
    exp_t e;
    int k;
    if (b2b) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (done !== 1'b1 && k < 200);
      if (done !== 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL b2b_wait_timeout: got done=%b expected 1 within 200 cycles", done);
      end
    end else begin
      @(negedge clk);
    end
    start = 1'b1;
    op    = o;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    SrcA  = $urandom;
    SrcB  = $urandom;
    if (push) begin
      e.hi   = eh;
      e.lo   = el;
      e.dz   = edz;
      e.dcyc = cyc + lat;
      e.name = name;
      sbq.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    SrcA  = '0;
    SrcB  = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi",   hi,       '0);
    chk("rst_lo",   lo,       '0);
    chk("rst_busy", busy,     1'b0);
    chk("rst_done", done,     1'b0);
    chk("rst_dz",   div_zero, 1'b0);
    reset = 1'b0;

    issue("mult_m3x5", 3'b000, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 0);
    wait_idle();
    issue("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 0);
    wait_idle();
    issue("mult_m1m1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 32'h00000001, 1'b0, 33, 0);
    wait_idle();
    issue("div_m7_2",  3'b010, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0);
    wait_idle();
    issue("divu_100_7", 3'b011, 32'd100, 32'd7, 1, 32'h00000002, 32'h0000000E, 1'b0, 33, 0);
    wait_idle();
    issue("div_minneg", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0, 33, 0);
    wait_idle();

    issue("mthi", 3'b100, 32'h12345678, 32'd0, 0, '0, '0, 1'b0, 0, 0);
    chk("mthi_hi",   hi,   32'h12345678);
    chk("mthi_lo",   lo,   32'h80000000);
    chk("mthi_busy", busy, 1'b0);

    issue("divu_5_0",  3'b011, 32'd5, 32'd0, 1, 32'h12345678, 32'h80000000, 1'b1, 1, 0);
    wait_idle();
    issue("multu_2x3", 3'b001, 32'd2, 32'd3, 1, 32'h00000000, 32'h00000006, 1'b0, 33, 0);
    wait_idle();

    // A start raised mid-CALC must be ignored; HI/LO hold during CALC
    issue("multu_3x4", 3'b001, 32'd3, 32'd4, 1, 32'h00000000, 32'h0000000C, 1'b0, 33, 0);
    repeat (10) @(negedge clk);
    chk("calc_busy", busy, 1'b1);
    chk("calc_hi",   hi,   32'h00000000);
    chk("calc_lo",   lo,   32'h00000006);
    start = 1'b1;
    op    = 3'b001;
    SrcA  = 32'd9;
    SrcB  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    issue("mult_m2x7",  3'b000, 32'hFFFFFFFE, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 33, 0);
    issue("divu_b2b",   3'b011, 32'd100, 32'd10, 1, 32'h00000000, 32'h0000000A, 1'b0, 33, 1);
    wait_idle();

    issue("rsvd", 3'b110, 32'hDEADBEEF, 32'd1, 0, '0, '0, 1'b0, 0, 0);
    chk("rsvd_busy", busy, 1'b0);
    chk("rsvd_hi",   hi,   32'h00000000);
    chk("rsvd_lo",   lo,   32'h0000000A);

    // Abort a divide with reset after 10 cycles of CALC
    issue("div_abort", 3'b010, 32'hFFFFFF9C, 32'd7, 0, '0, '0, 1'b0, 0, 0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_hi",   hi,       '0);
    chk("abort_lo",   lo,       '0);
    chk("abort_busy", busy,     1'b0);
    chk("abort_done", done,     1'b0);
    chk("abort_dz",   div_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("abort_quiet", seen, 0);

    issue("mtlo", 3'b101, 32'h0000ABCD, 32'd0, 0, '0, '0, 1'b0, 0, 0);
    chk("mtlo_lo",   lo,   32'h0000ABCD);
    chk("mtlo_hi",   hi,   32'h00000000);
    chk("mtlo_busy", busy, 1'b0);
    @(negedge clk);
    chk("mtlo_busy2", busy, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
